// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg
//   Shared definitions for the LC-3 main-memory arbiter:
//   - arb_state_e : sequencing FSM states (IDLE / ACCESS / DONE)
//   - OWNER_CPU / OWNER_LDR : encoding of the grant owner bit
//   - DEFAULT_MEM_LATENCY : default number of memory access cycles
//   - CNT_W : width of the access-cycle counter (covers latency 1..15)
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LDR = 1'b1;

  localparam int DEFAULT_MEM_LATENCY = 3;
  localparam int CNT_W               = 4;

endpackage

// File: rtl/lc3_mem_arb_pick.sv
// lc3_mem_arb_pick
//   Combinational winner selection between the CPU and loader requesters.
//   Configuration macro: LC3_ARB_ROUND_ROBIN_EN
//     defined   : on a tie, grant the requester that was not granted last
//     undefined : fixed priority, the CPU wins every tie
//   A lone requester is always granted.
// Ports:
//   i_cpu_req     in  CPU request
//   i_ldr_req     in  loader request
//   i_last_owner  in  owner of the most recent grant (tie-break history)
//   o_grant_valid out at least one request is present
//   o_winner      out OWNER_CPU / OWNER_LDR
module lc3_mem_arb_pick
  import lc3_mem_pkg::*;
(
  input  logic i_cpu_req,
  input  logic i_ldr_req,
  input  logic i_last_owner,
  output logic o_grant_valid,
  output logic o_winner
);

  logic tie_winner;

`ifdef LC3_ARB_ROUND_ROBIN_EN
  assign tie_winner = ~i_last_owner;
`else
  // History is irrelevant under fixed priority.
  logic unused_last_owner;
  assign unused_last_owner = i_last_owner;
  assign tie_winner        = OWNER_CPU;
`endif

  always_comb begin
    o_grant_valid = i_cpu_req | i_ldr_req;
    o_winner      = OWNER_CPU;
    if (i_cpu_req && i_ldr_req) begin
      o_winner = tie_winner;
    end else if (i_ldr_req) begin
      o_winner = OWNER_LDR;
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter
//   Shares the LC-3 single-ported main memory between the CPU memory
//   interface (MAR/MDR) and a program loader/debug port. Each access runs
//   IDLE -> ACCESS (MEM_LATENCY cycles) -> DONE, where the owner's Ready
//   (the LC-3 R bit) pulses for one cycle alongside its registered RData.
//   Configuration macro: LC3_ARB_ROUND_ROBIN_EN (tie policy, see
//   lc3_mem_arb_pick).
// Ports:
//   i_CLK, i_Reset                     clock / async active-high reset
//   i_Cpu_Req/WE/Addr/WData            CPU request, held until Ready
//   o_Cpu_Ready, o_Cpu_RData           CPU completion pulse, read data
//   i_Ldr_Req/WE/Addr/WData            loader request, held until Ready
//   o_Ldr_Ready, o_Ldr_RData           loader completion pulse, read data
//   o_Mem_En, o_Mem_WE                 memory enable / write strobe
//   o_Mem_Addr, o_Mem_WData            latched address / write data
//   i_Mem_RData                        memory read data
//   o_Busy                             FSM not in IDLE
//   o_Owner                            current/last grant (0 CPU, 1 loader)
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              i_CLK,
  input  logic              i_Reset,
  input  logic              i_Cpu_Req,
  input  logic              i_Cpu_WE,
  input  logic [ADDR_W-1:0] i_Cpu_Addr,
  input  logic [DATA_W-1:0] i_Cpu_WData,
  output logic              o_Cpu_Ready,
  output logic [DATA_W-1:0] o_Cpu_RData,
  input  logic              i_Ldr_Req,
  input  logic              i_Ldr_WE,
  input  logic [ADDR_W-1:0] i_Ldr_Addr,
  input  logic [DATA_W-1:0] i_Ldr_WData,
  output logic              o_Ldr_Ready,
  output logic [DATA_W-1:0] o_Ldr_RData,
  output logic              o_Mem_En,
  output logic              o_Mem_WE,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [DATA_W-1:0] o_Mem_WData,
  input  logic [DATA_W-1:0] i_Mem_RData,
  output logic              o_Busy,
  output logic              o_Owner
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  logic              last_owner;
  logic              grant_valid;
  logic              winner;

  // Tie-break history. Round-robin keeps its own register that starts at
  // the loader so the CPU wins the first tie, while o_Owner resets to CPU.
`ifdef LC3_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && grant_valid) begin
      last_d = winner;
    end
  end

  always_ff @(posedge i_CLK or posedge i_Reset) begin
    if (i_Reset) begin
      last_q <= OWNER_LDR;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_owner = last_q;
`else
  assign last_owner = owner_q;
`endif

  lc3_mem_arb_pick u_pick (
    .i_cpu_req     (i_Cpu_Req),
    .i_ldr_req     (i_Ldr_Req),
    .i_last_owner  (last_owner),
    .o_grant_valid (grant_valid),
    .o_winner      (winner)
  );

  // Request inputs are only looked at in IDLE; from the grant edge on the
  // access runs entirely from the latched copies.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    owner_d     = owner_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = winner;
          cnt_d   = LAT_M1;
          state_d = ACCESS;
          if (winner == OWNER_LDR) begin
            we_d    = i_Ldr_WE;
            addr_d  = i_Ldr_Addr;
            wdata_d = i_Ldr_WData;
          end else begin
            we_d    = i_Cpu_WE;
            addr_d  = i_Cpu_Addr;
            wdata_d = i_Cpu_WData;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q == OWNER_LDR) begin
              ldr_rdata_d = i_Mem_RData;
            end else begin
              cpu_rdata_d = i_Mem_RData;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= OWNER_CPU;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  // Outputs decode registered state only, so no Req reaches an output
  // combinationally. The write strobe is confined to the last ACCESS cycle
  // so each write commits exactly once.
  assign o_Mem_En    = (state_q == ACCESS);
  assign o_Mem_WE    = (state_q == ACCESS) && (cnt_q == '0) && we_q;
  assign o_Mem_Addr  = addr_q;
  assign o_Mem_WData = wdata_q;
  assign o_Busy      = (state_q != IDLE);
  assign o_Owner     = owner_q;
  assign o_Cpu_Ready = (state_q == DONE) && (owner_q == OWNER_CPU);
  assign o_Ldr_Ready = (state_q == DONE) && (owner_q == OWNER_LDR);
  assign o_Cpu_RData = cpu_rdata_q;
  assign o_Ldr_RData = ldr_rdata_q;

endmodule
